// File: rtl/boxcar_pkg.sv
// boxcar_pkg: shared widths and state encoding for the 16-tap boxcar accumulator
package boxcar_pkg;
  localparam int DIN_W = 12;
  localparam int LOG2_N = 4;
  localparam int N = 1 << LOG2_N;
  localparam int DOUT_W = DIN_W + LOG2_N;
  typedef enum logic {FILL, RUN} state_t;
endpackage

// File: rtl/boxcar_ring16.sv
// boxcar_ring16: 16-entry flop ring buffer exposing the oldest entry before it is overwritten
module boxcar_ring16
  import boxcar_pkg::*;
(
  input  logic                     clk,
  input  logic                     zero_i,
  input  logic                     we_i,
  input  logic signed [DIN_W-1:0]  wdata_i,
  output logic signed [DIN_W-1:0]  oldest_o
);
  logic [N-1:0][DIN_W-1:0] mem_q;
  logic [LOG2_N-1:0] wr_ptr_q;
  always_ff @(posedge clk) begin
    if (zero_i) begin
      mem_q <= '0;
      wr_ptr_q <= '0;
    end else if (we_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_q + LOG2_N'(1);
    end
  end
  assign oldest_o = mem_q[wr_ptr_q];
endmodule

// File: rtl/boxcar_sum16.sv
// boxcar_sum16: exact running sum of the last 16 accepted signed samples
module boxcar_sum16
  import boxcar_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     din_valid,
  input  logic signed [DIN_W-1:0]  din,
  output logic                     dout_valid,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     primed
);
  logic zero;
  logic signed [DIN_W-1:0] oldest;
  logic signed [DOUT_W-1:0] acc_q, acc_d;
  logic [LOG2_N:0] fill_q, fill_d;
  state_t state_q, state_d;
  logic dout_valid_q;
  assign zero = !rst_n || clear;
  boxcar_ring16 u_ring (
    .clk     (clk),
    .zero_i  (zero),
    .we_i    (din_valid && !zero),
    .wdata_i (din),
    .oldest_o(oldest)
  );
  // Wraps modulo 2^DOUT_W; the settled sum always fits, so no guard is needed.
  always_comb begin
    acc_d = acc_q + DOUT_W'(din) - DOUT_W'(oldest);
    fill_d = (fill_q == (LOG2_N+1)'(N)) ? fill_q : fill_q + (LOG2_N+1)'(1);
    state_d = (state_q == RUN || fill_q == (LOG2_N+1)'(N-1)) ? RUN : FILL;
  end
  always_ff @(posedge clk) begin
    if (zero) begin
      acc_q <= '0;
      fill_q <= '0;
      state_q <= FILL;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= din_valid && state_d == RUN;
      if (din_valid) begin
        acc_q <= acc_d;
        fill_q <= fill_d;
        state_q <= state_d;
      end
    end
  end
  assign dout = acc_q;
  assign dout_valid = dout_valid_q;
  assign primed = state_q == RUN;
endmodule

// File: tb/tb_boxcar_sum16.sv
// tb_boxcar_sum16: directed vector table, multi-cycle corner sequences and a FIFO-sum scoreboard
module tb_boxcar_sum16;
  import boxcar_pkg::*;
  logic clk, rst_n, clear, din_valid;
  logic signed [DIN_W-1:0] din;
  logic dout_valid, primed;
  logic signed [DOUT_W-1:0] dout;
  int total = 0, bad = 0;
  int mq[$];
  int mcnt = 0;
  typedef struct {
    logic rn, cl, v;
    int d;
    logic ev;
    int ed;
    logic ep;
  } vec_t;
  vec_t vt[$];

  boxcar_sum16 dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din_valid(din_valid), .din(din),
    .dout_valid(dout_valid), .dout(dout), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(logic rn, logic cl, logic v, int d, logic ev, int ed, logic ep);
    vt.push_back('{rn: rn, cl: cl, v: v, d: d, ev: ev, ed: ed, ep: ep});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic cl, input logic v, input int d);
    @(negedge clk);
    rst_n = rn;
    clear = cl;
    din_valid = v;
    din = DIN_W'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input int ed, input logic ep);
    int sd;
    sd = dout;
    chk({tag, ".valid"}, int'(dout_valid), int'(ev));
    chk({tag, ".dout"}, sd, ed);
    chk({tag, ".primed"}, int'(primed), int'(ep));
  endtask

  function automatic int msum();
    int s = 0;
    foreach (mq[i]) s += mq[i];
    return s;
  endfunction

  function automatic int floor16(int s);
    return (s - (((s % 16) + 16) % 16)) / 16;
  endfunction

  task automatic model_step(input string tag, input logic v, input int d);
    int sd, sx;
    sx = d;
    if (sx >= 2048) sx -= 4096;
    drive(1'b1, 1'b0, v, sx);
    if (v) begin
      mq.push_back(sx);
      if (mq.size() > N) void'(mq.pop_front());
      mcnt++;
    end
    check_out(tag, v && mcnt >= N, msum(), mcnt >= N);
    sd = dout;
    if (v && mcnt >= N) chk({tag, ".shift4"}, sd >>> 4, floor16(msum()));
  endtask

  task automatic model_clear();
    drive(1'b1, 1'b1, 1'b0, 0);
    check_out("mclear", 1'b0, 0, 1'b0);
    mq.delete();
    mcnt = 0;
  endtask

  initial begin
    int vcount;
    bit primed_ok;
    rst_n = 1'b0;
    clear = 1'b0;
    din_valid = 1'b0;
    din = '0;
    add(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(1, 0, 1, 100, i == 16, 100 * i, i == 16);
    add(1, 0, 1, 0, 1, 1500, 1);
    add(1, 0, 0, 55, 0, 1500, 1);
    add(1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(1, 0, 1, -2048, i == 16, -2048 * i, i == 16);
    for (int i = 1; i <= 16; i++) add(1, 0, 1, 2047, 1, -32768 + 4095 * i, 1);
    add(1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add(1, 0, 1, 50, 0, 50 * i, 0);
    add(1, 1, 1, 999, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(1, 0, 1, 1, i == 16, i, i == 16);
    add(0, 0, 1, 321, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(1, 0, 1, 7, i == 16, 7 * i, i == 16);
    add(1, 0, 1, -7, 1, 98, 1);
    foreach (vt[k]) begin
      drive(vt[k].rn, vt[k].cl, vt[k].v, vt[k].d);
      check_out($sformatf("vec%0d", k), vt[k].ev, vt[k].ed, vt[k].ep);
    end

    model_clear();
    vcount = 0;
    primed_ok = 1'b1;
    for (int s = 0; s < 32; s++) begin
      int gaps;
      gaps = $urandom_range(0, 5);
      for (int g = 0; g < gaps; g++) model_step("ramp_gap", 1'b0, 0);
      model_step($sformatf("ramp%0d", s), 1'b1, s);
      if (dout_valid) vcount++;
      if (mcnt >= N && !primed) primed_ok = 1'b0;
      if (mcnt == 16) chk("ramp_s16", int'(dout), 120);
      if (mcnt == 32) chk("ramp_s32", int'(dout), 376);
    end
    chk("ramp_valid_count", vcount, 17);
    chk("ramp_primed_held", int'(primed_ok), 1);

    model_clear();
    for (int r = 0; r < 10000; r++)
      model_step("rand", $urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/boxcar_sum16.md
# boxcar_sum16

Sliding-window accumulator that keeps the exact running sum of the last 16 accepted 12-bit signed samples and emits it as a 16-bit signed word. It sits directly upstream of the fixed arithmetic-right-shift-by-4 stage in the single-channel modem datapath. That stage divides the sum by 16, so the pair forms a 16-tap moving-average (boxcar) filter. The sum is exact by construction: 16 × 12-bit fits in 16 bits, so no saturation or rounding is needed.

## Interface
- DIN_W, 12, input sample width (signed two's complement)
- LOG2_N, 4, log2 of window length; the window length N is 16
- DOUT_W, 16, output width; fixed as DIN_W + LOG2_N
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  reset; synchronous and active-low
- clear  in  1  synchronous flush of the window; has the same effect as reset
- din_valid  in  1  qualifies din; one sample is accepted per cycle while high
- din  in  DIN_W  signed input sample
- dout_valid  out  1  one-cycle pulse per accepted sample, once the window is full
- dout  out  DOUT_W  signed sum of the last 16 accepted samples, registered
- primed  out  1  high once 16 samples have been accepted since the last reset or clear

## Operation
- Storage:
  - 16-entry ring buffer of DIN_W-bit words.
  - 4-bit write pointer wr_ptr.
  - DOUT_W-bit accumulator acc.
  - 5-bit fill counter fill, which saturates at 16.
- Accepted sample (din_valid = 1, clear = 0, rst_n = 1), all updates in the same edge:
  - acc ← acc + sext(din) − sext(buf[wr_ptr])
  - buf[wr_ptr] ← din
  - wr_ptr ← wr_ptr + 1, wrapping modulo 16
  - fill ← min(fill + 1, 16)
- Arithmetic:
  - All terms are sign-extended to DOUT_W before the add/subtract.
  - The intermediate result wraps modulo 2^DOUT_W.
  - The final acc is always within [−32768, 32752], so no overflow logic exists.
- States:
  - FILL: fill < 16. Transition to RUN on the acceptance that brings fill to 16.
  - RUN: remains in RUN until reset or clear.
- dout/dout_valid:
  - dout ← the new acc value.
  - dout_valid ← 1 only when the acceptance happens in RUN, or is the FILL→RUN transition sample.
  - In FILL, dout still updates but dout_valid stays 0.
- din_valid = 0: all state holds and dout_valid ← 0. Gaps of any length are allowed; the window counts samples, not cycles.
- clear = 1, or rst_n = 0:
  - All buffer entries ← 0.
  - acc, wr_ptr, fill ← 0.
  - State ← FILL.
  - dout ← 0, dout_valid ← 0, primed ← 0.
- Priority: rst_n > clear > din_valid. A sample presented in the same cycle as clear or reset is dropped.
- primed is asserted combinationally from (state == RUN).

## Timing
- Latency: 1 cycle. The sample accepted at edge k is reflected in dout and dout_valid after edge k. No back-pressure exists.
- Throughput: 1 sample per cycle sustained.
- Reset values: dout = 0, dout_valid = 0, primed = 0, and all internal state = 0.
- First dout_valid: after the edge that accepts the 16th sample following reset or clear.
- Reset or clear mid-operation takes effect at that edge. The next accepted sample is sample 1 of a new window.
- The wr_ptr wrap from 15→0 needs no special handling. The oldest sample is always buf[wr_ptr].

## Structure
- Shared package boxcar_pkg holds:
  - the constants DIN_W, LOG2_N, N = 1 << LOG2_N, DOUT_W = DIN_W + LOG2_N
  - the state enum {FILL, RUN}
- Sub-module boxcar_ring16:
  - Contents: the 16 × DIN_W register file with a resettable wr_ptr.
  - Ports: write-enable, write data, synchronous zeroing, and read-before-write output of the oldest entry.
  - Implemented as flops (not RAM), so zeroing is single-cycle.
- The top level holds acc, fill, state and the output registers.

## Test plan
- 16 consecutive samples of +100 → dout_valid low for samples 1–15 and first high with dout = 1600 on sample 16. A 17th sample of 0 → dout = 1500, dout_valid = 1.
- 16 samples of −2048 → dout = −32768. Then 16 samples of +2047 → dout climbs by 4095 per sample and ends at +32752, with no wrap error.
- Ramp 0..31 with random din_valid gaps of 0–5 cycles → each valid dout equals the sum of the last 16 accepted values (sample 16 → 120, sample 32 → 376). dout_valid count = 17 and primed stays high.
- clear asserted after 10 samples of +50, with din_valid = 1 in the same cycle → the sample is dropped and dout = 0. The next 16 samples of +1 give the first dout_valid with dout = 16.
- rst_n pulled low for 1 cycle in RUN → all outputs are 0 on the next cycle. Then 15 samples give no dout_valid and the 16th gives dout_valid.
- Scoreboard against a reference model of a 16-deep FIFO sum, with 10k random full-range samples → zero mismatches. When chained with the shift-by-4 stage, the result equals floor(sum/16).
